operand_load_stage: RTL
=======================

# operand_load_stage

Operand-capture stage directly downstream of the controller's registered load-control bus. On each accepted load command it forms operand A and operand B from register-file read data, the next PC and immediate fields of the held instruction word, with writeback forwarding. It then presents the pair to the execute stage through a valid/ready handshake. A one-entry skid buffer absorbs a single execute-side backpressure cycle without losing a command.

## Interface
- DATA_WIDTH, 32, operand/PC/instruction width (architecture-fixed)
- REG_INDEX_WIDTH, 5, register index width
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 clears state at the next clk edge)
- enable  in  1  controller advance strobe; gates acceptance of new load commands only
- loadControl  in  loadGroup::controlBus  registered operand-select command; NO_OP means no load
- instruction  in  DATA_WIDTH  held instruction word belonging to loadControl
- nextPc  in  DATA_WIDTH  PC of following instruction
- rfAData, rfBData  in  DATA_WIDTH  register-file read ports
- rfAIndex, rfBIndex  in  REG_INDEX_WIDTH  indices being read
- wbValid  in  1  writeback this cycle
- wbIndex  in  REG_INDEX_WIDTH  writeback destination
- wbData  in  DATA_WIDTH  writeback value
- opReady  in  1  execute accepts the output pair
- operandA, operandB  out  DATA_WIDTH  registered operands
- operandSrc  out  loadGroup::controlBus  command that produced the current operands
- operandValid  out  1  output pair is valid
- stallRequest  out  1  registered; high while the skid entry is occupied

## Operation
- Accept: enable==1 and loadControl!=NO_OP.
- Forwarding: effective A = wbData when wbValid and wbIndex==rfAIndex, else rfAData. Effective B follows the same rule with rfBIndex. No register index is special.
- Forming (imm fields from instruction):
  - NEXTPC_IMM24: A=nextPc, B=sext(instr[23:0])<<2.
  - NEXTPC_IMM21: A=nextPc, B=sext(instr[20:0]).
  - RFA_RFB: A=rfA, B=rfB.
  - RFA_IMM19: A=rfA, B=sext(instr[18:0]).
  - RFA_IMM16: A=rfA, B=sext(instr[15:0]).
  - RFA_IMM5: A=rfA, B=zext(instr[4:0]).
  - RFA_NULL: A=rfA, B=0.
  - COMBO_NULL: A={instr[15:0], rfA[15:0]}, B=0.
  - All arithmetic is width-truncated to DATA_WIDTH.
- Slots: the output register (operandValid) and the skid register (skidValid). Each slot holds A, B and src.
- Drain: an output drains when operandValid && opReady.
- Per-cycle priority:
  1. Output empty or draining, skid valid: skid moves to output. An accepted command goes to skid.
  2. Output empty or draining, skid empty: an accepted command goes to output.
  3. Output held (valid, !opReady): an accepted command goes to skid if skid is empty.
  4. An accepted command while skid is full and the output is held is dropped. This is a protocol violation; the bench asserts it never occurs.
- stallRequest = skidValid (registered). The controller deasserts enable while it is high.
- enable==0 does not freeze draining or skid-to-output transfer.

## Timing
- Reset values: operandValid=0, skidValid=0, stallRequest=0, operandA=0, operandB=0, operandSrc=NO_OP.
- Latency: command accepted in cycle N appears on the outputs in cycle N+1 when the output path is free. Via skid it appears no earlier than N+2.
- The handshake completes in the cycle operandValid && opReady. The next pair may be valid in the following cycle.
- Back-to-back accepts with opReady held high give one pair per cycle, and stallRequest stays 0.
- Forwarding uses wbValid/wbIndex/wbData sampled in the accept cycle only. Values captured into a slot are never re-forwarded.
- Reset mid-operation: both slots are discarded at the next edge. A command present in the reset cycle is not captured.

## Structure
- loadGroup already provides controlBus and NO_OP, and this block reuses them.
- A shared package operandPkg holds the immediate field MSB constants (23, 20, 18, 15, 4) and the IMM24 shift amount (2).
- Sub-module operand_former is purely combinational: forwarding muxes plus immediate extraction and operand selection. The top level holds the two slots and the handshake logic.

## Test plan
- RFA_RFB accepted, rfA=0x11, rfB=0x22, opReady=1 -> next cycle A=0x11, B=0x22, operandValid=1, src=RFA_RFB.
- NEXTPC_IMM24, nextPc=0x100, instr[23:0]=0xFFFFFE -> A=0x100, B=0xFFFFFFF8. RFA_IMM5 with instr[4:0]=0x1F -> B=0x1F.
- COMBO_NULL, instr[15:0]=0xABCD, rfA=0x12345678 -> A=0xABCD5678, B=0.
- Forwarding: wbValid=1, wbIndex=rfAIndex=3, wbData=0xDEAD, rfAData=0 -> A=0xDEAD.
- opReady=0 with two accepts -> second command goes to skid, stallRequest=1. Then opReady=1 -> pairs delivered in order on consecutive cycles and stallRequest returns to 0.
- reset=0 asserted while both slots are full -> after the edge, operandValid=0, stallRequest=0, operandSrc=NO_OP.

Source files
------------

// File: rtl/load_group_pkg.sv
`default_nettype none
//============================================================================
// Package : loadGroup
// Brief   : Load-control command bus driven by the controller.
// Rev     : 1.0
//============================================================================
package loadGroup;

    typedef enum logic [3:0] {
        NO_OP        = 4'd0,
        NEXTPC_IMM24 = 4'd1,
        NEXTPC_IMM21 = 4'd2,
        RFA_RFB      = 4'd3,
        RFA_IMM19    = 4'd4,
        RFA_IMM16    = 4'd5,
        RFA_IMM5     = 4'd6,
        RFA_NULL     = 4'd7,
        COMBO_NULL   = 4'd8
    } controlBus;

endpackage
`default_nettype wire

// File: rtl/operand_load_stage_pkg.sv
`default_nettype none
//============================================================================
// Package : operandPkg
// Brief   : Immediate field positions shared by the operand-capture logic.
// Rev     : 1.0
//============================================================================
package operandPkg;

    localparam int c_imm24_msb   = 23;
    localparam int c_imm21_msb   = 20;
    localparam int c_imm19_msb   = 18;
    localparam int c_imm16_msb   = 15;
    localparam int c_imm5_msb    = 4;
    localparam int c_imm24_shift = 2;

endpackage
`default_nettype wire

// File: rtl/operand_load_stage_former.sv
`default_nettype none
//============================================================================
// Module : operand_former
// Brief  : Combinational writeback forwarding, immediate extraction and
//          operand selection for one load command.
// Rev    : 1.0
//============================================================================
module operand_former
    import loadGroup::*;
    import operandPkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_INDEX_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]      i_instruction,
    input  logic [DATA_WIDTH-1:0]      i_next_pc,
    input  controlBus                  i_load_control,
    input  logic [DATA_WIDTH-1:0]      i_rf_a_data,
    input  logic [DATA_WIDTH-1:0]      i_rf_b_data,
    input  logic [REG_INDEX_WIDTH-1:0] i_rf_a_index,
    input  logic [REG_INDEX_WIDTH-1:0] i_rf_b_index,
    input  logic                       i_wb_valid,
    input  logic [REG_INDEX_WIDTH-1:0] i_wb_index,
    input  logic [DATA_WIDTH-1:0]      i_wb_data,
    output logic [DATA_WIDTH-1:0]      o_operand_a,
    output logic [DATA_WIDTH-1:0]      o_operand_b
);

    logic [DATA_WIDTH-1:0] w_eff_a;
    logic [DATA_WIDTH-1:0] w_eff_b;
    logic [DATA_WIDTH-1:0] w_imm24;
    logic [DATA_WIDTH-1:0] w_imm21;
    logic [DATA_WIDTH-1:0] w_imm19;
    logic [DATA_WIDTH-1:0] w_imm16;
    logic [DATA_WIDTH-1:0] w_imm5;
    logic [DATA_WIDTH-1:0] w_combo;

    assign w_eff_a = (i_wb_valid && (i_wb_index == i_rf_a_index)) ? i_wb_data : i_rf_a_data;
    assign w_eff_b = (i_wb_valid && (i_wb_index == i_rf_b_index)) ? i_wb_data : i_rf_b_data;

    assign w_imm24 = {{(DATA_WIDTH-c_imm24_msb-1){i_instruction[c_imm24_msb]}},
                      i_instruction[c_imm24_msb:0]} << c_imm24_shift;
    assign w_imm21 = {{(DATA_WIDTH-c_imm21_msb-1){i_instruction[c_imm21_msb]}},
                      i_instruction[c_imm21_msb:0]};
    assign w_imm19 = {{(DATA_WIDTH-c_imm19_msb-1){i_instruction[c_imm19_msb]}},
                      i_instruction[c_imm19_msb:0]};
    assign w_imm16 = {{(DATA_WIDTH-c_imm16_msb-1){i_instruction[c_imm16_msb]}},
                      i_instruction[c_imm16_msb:0]};
    assign w_imm5  = {{(DATA_WIDTH-c_imm5_msb-1){1'b0}}, i_instruction[c_imm5_msb:0]};
    // Upper half from the instruction, lower half from register A.
    assign w_combo = {i_instruction[c_imm16_msb:0], w_eff_a[c_imm16_msb:0]};

    always_comb begin
        o_operand_a = w_eff_a;
        o_operand_b = '0;
        case (i_load_control)
            NEXTPC_IMM24: begin o_operand_a = i_next_pc; o_operand_b = w_imm24; end
            NEXTPC_IMM21: begin o_operand_a = i_next_pc; o_operand_b = w_imm21; end
            RFA_RFB:      o_operand_b = w_eff_b;
            RFA_IMM19:    o_operand_b = w_imm19;
            RFA_IMM16:    o_operand_b = w_imm16;
            RFA_IMM5:     o_operand_b = w_imm5;
            RFA_NULL:     o_operand_b = '0;
            COMBO_NULL:   o_operand_a = w_combo;
            default:      o_operand_a = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/operand_load_stage.sv
`default_nettype none
//============================================================================
// Module : operand_load_stage
// Brief  : Captures operand pairs for accepted load commands and hands them
//          to execute over valid/ready, with a one-entry skid buffer.
// Rev    : 1.0
//============================================================================
module operand_load_stage
    import loadGroup::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_INDEX_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  controlBus                  loadControl,
    input  logic [DATA_WIDTH-1:0]      instruction,
    input  logic [DATA_WIDTH-1:0]      nextPc,
    input  logic [DATA_WIDTH-1:0]      rfAData,
    input  logic [DATA_WIDTH-1:0]      rfBData,
    input  logic [REG_INDEX_WIDTH-1:0] rfAIndex,
    input  logic [REG_INDEX_WIDTH-1:0] rfBIndex,
    input  logic                       wbValid,
    input  logic [REG_INDEX_WIDTH-1:0] wbIndex,
    input  logic [DATA_WIDTH-1:0]      wbData,
    input  logic                       opReady,
    output logic [DATA_WIDTH-1:0]      operandA,
    output logic [DATA_WIDTH-1:0]      operandB,
    output controlBus                  operandSrc,
    output logic                       operandValid,
    output logic                       stallRequest
);

    logic [DATA_WIDTH-1:0] w_formed_a;
    logic [DATA_WIDTH-1:0] w_formed_b;
    logic                  w_accept;
    logic                  w_out_free;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_a;
    logic [DATA_WIDTH-1:0] r_out_b;
    controlBus             r_out_src;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_a;
    logic [DATA_WIDTH-1:0] r_skid_b;
    controlBus             r_skid_src;

    operand_former #(
        .DATA_WIDTH      (DATA_WIDTH),
        .REG_INDEX_WIDTH (REG_INDEX_WIDTH)
    ) u_former (
        .i_instruction  (instruction),
        .i_next_pc      (nextPc),
        .i_load_control (loadControl),
        .i_rf_a_data    (rfAData),
        .i_rf_b_data    (rfBData),
        .i_rf_a_index   (rfAIndex),
        .i_rf_b_index   (rfBIndex),
        .i_wb_valid     (wbValid),
        .i_wb_index     (wbIndex),
        .i_wb_data      (wbData),
        .o_operand_a    (w_formed_a),
        .o_operand_b    (w_formed_b)
    );

    assign w_accept   = enable && (loadControl != NO_OP);
    assign w_out_free = !r_out_valid || opReady;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_src    <= NO_OP;
            r_skid_valid <= 1'b0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_skid_src   <= NO_OP;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Older skid entry goes out first; a new command refills skid.
                r_out_valid  <= 1'b1;
                r_out_a      <= r_skid_a;
                r_out_b      <= r_skid_b;
                r_out_src    <= r_skid_src;
                r_skid_valid <= w_accept;
                if (w_accept) begin
                    r_skid_a   <= w_formed_a;
                    r_skid_b   <= w_formed_b;
                    r_skid_src <= loadControl;
                end
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_a   <= w_formed_a;
                    r_out_b   <= w_formed_b;
                    r_out_src <= loadControl;
                end
            end
        end else if (w_accept && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_a     <= w_formed_a;
            r_skid_b     <= w_formed_b;
            r_skid_src   <= loadControl;
        end
    end

    assign operandA     = r_out_a;
    assign operandB     = r_out_b;
    assign operandSrc   = r_out_src;
    assign operandValid = r_out_valid;
    assign stallRequest = r_skid_valid;

endmodule
`default_nettype wire
